// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared constants for the MAC pipeline and its result collector
//
// Purpose : latency, default data width and err bit positions used by the
//           result collector and anything that models the MAC pipeline.
// Ports   : none (package).
package mac_pkg;

    // Multiply takes 5 cycles and add takes 2.
    localparam int MAC_LATENCY = 7;
    localparam int MAC_WIDTH   = 32;

    localparam int ERR_OVF  = 0;
    localparam int ERR_SPUR = 1;

endpackage

// File: rtl/mac_result_fifo.sv
// rtl/mac_result_fifo.sv - first-word-fall-through result storage
//
// Purpose : DEPTH-entry FWFT FIFO. The head is read combinationally, so
//           head_data is valid in the same cycle head_valid is high.
// Ports   : clk, aclr         clock, synchronous active-high reset
//           push, push_data   write request and data
//           pop               advance head (ignored while empty)
//           head_valid        FIFO not empty
//           head_data         mem[rd_ptr]
//           count             occupancy, AW+1 bits
//           full              count == DEPTH
module mac_result_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             aclr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic [AW:0]      count,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_en;
    logic             wr_en;

    assign head_valid = (count != '0);
    assign head_data  = mem[rd_ptr];
    assign full       = (count == (AW+1)'(DEPTH));

    assign pop_en = pop && head_valid;
    // A write while full is only allowed when the head leaves in the same cycle.
    assign wr_en  = push && (!full || pop_en);

    always_ff @(posedge clk) begin
        if (aclr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
            if (pop_en) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop_en};
        end
    end

    // Storage has no reset; contents are don't-care while count is 0.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mac_result_collector.sv
// rtl/mac_result_collector.sv - MAC pipeline tail: result capture and issue credits
//
// Purpose : captures every non-NOP pipeline result into a FWFT FIFO, presents
//           it on a valid/ready output and grants issue credits so the
//           non-stallable pipeline can never overflow the FIFO.
//           Optional macro MAC_COLLECT_ERR_EN enables sticky error flags.
// Ports   : clk, aclr                  clock, synchronous active-high reset
//           issue_valid, issue_ready   upstream launch handshake (credit)
//           res_nop, res_data          pipeline tail; res_nop=1 is a bubble
//           out_valid, out_ready       FIFO head handshake
//           out_data                   FIFO head data
//           fifo_count                 FIFO occupancy
//           err                        [0] overflow, [1] spurious result
module mac_result_collector
    import mac_pkg::*;
#(
    parameter int WIDTH = MAC_WIDTH,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             aclr,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic             res_nop,
    input  logic [WIDTH-1:0] res_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [AW:0]      fifo_count,
    output logic [1:0]       err
);

    // used = FIFO entries + ops still travelling through the pipeline.
    logic [AW:0] used;
    logic        issue_fire;
    logic        pop_fire;
    logic        push;
    logic        full;

    assign issue_ready = (used < (AW+1)'(DEPTH));
    assign issue_fire  = issue_valid && issue_ready;
    assign pop_fire    = out_valid && out_ready;
    // An overflowing result is dropped here rather than written.
    assign push        = !res_nop && (!full || pop_fire);

    always_ff @(posedge clk) begin
        if (aclr) begin
            used <= '0;
        end else begin
            used <= used + {{AW{1'b0}}, issue_fire} - {{AW{1'b0}}, pop_fire};
        end
    end

    mac_result_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk        (clk),
        .aclr       (aclr),
        .push       (push),
        .push_data  (res_data),
        .pop        (pop_fire),
        .head_valid (out_valid),
        .head_data  (out_data),
        .count      (fifo_count),
        .full       (full)
    );

`ifdef MAC_COLLECT_ERR_EN
    logic [1:0] err_q;

    always_ff @(posedge clk) begin
        if (aclr) begin
            err_q <= 2'b00;
        end else begin
            if (!res_nop && full && !pop_fire) err_q[ERR_OVF] <= 1'b1;
            // Every in-flight credit is already sitting in the FIFO, so this
            // result was never issued through the credit path.
            if (!res_nop && (fifo_count == used)) err_q[ERR_SPUR] <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 2'b00;
`endif

endmodule

// File: tb/tb_mac_result_collector.sv
// tb/tb_mac_result_collector.sv - self-checking bench for mac_result_collector
module tb_mac_result_collector;
    import mac_pkg::*;

    localparam int WIDTH = 32;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

`ifdef MAC_COLLECT_ERR_EN
    localparam logic [1:0] EXP_SPUR = 2'b10;
    localparam logic [1:0] EXP_BOTH = 2'b11;
`else
    localparam logic [1:0] EXP_SPUR = 2'b00;
    localparam logic [1:0] EXP_BOTH = 2'b00;
`endif

    logic             clk = 1'b0;
    logic             aclr;
    logic             issue_valid;
    logic             issue_ready;
    logic             res_nop;
    logic [WIDTH-1:0] res_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [AW:0]      fifo_count;
    logic [1:0]       err;

    always #5 clk = ~clk;

    mac_result_collector #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .aclr        (aclr),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .res_nop     (res_nop),
        .res_data    (res_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .fifo_count  (fifo_count),
        .err         (err)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: FIFO contents as a queue, credits as a modular count.
    logic [WIDTH-1:0] model_q[$];
    int               m_used;
    logic [1:0]       m_err;

    // Upstream pipeline model feeding the tail.
    logic             pipe_nop  [MAC_LATENCY];
    logic [WIDTH-1:0] pipe_data [MAC_LATENCY];

    // Forced tail value for error scenarios.
    bit               ovr_en;
    logic             ovr_nop;
    logic [WIDTH-1:0] ovr_data;

    // Observations taken from the DUT.
    logic [WIDTH-1:0] dut_popped[$];
    int               dut_fires;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_err();
`ifdef MAC_COLLECT_ERR_EN
        return m_err;
`else
        return 2'b00;
`endif
    endfunction

    task automatic model_clear();
        model_q.delete();
        m_used = 0;
        m_err  = 2'b00;
        for (int i = 0; i < MAC_LATENCY; i++) begin
            pipe_nop[i]  = 1'b1;
            pipe_data[i] = $urandom;
        end
        ovr_en = 1'b0;
    endtask

    task automatic do_reset();
        aclr        = 1'b1;
        issue_valid = 1'b0;
        out_ready   = 1'b0;
        res_nop     = 1'b1;
        res_data    = '0;
        repeat (3) @(posedge clk);
        #1;
        aclr = 1'b0;
        model_clear();
    endtask

    // One clock cycle: check the visible state, drive inputs, advance the
    // model by the cycle's events, then move to 1 ns after the next edge.
    task automatic tick(input bit iv, input bit ordy, input logic [WIDTH-1:0] d);
        bit               ifire;
        bit               pfire;
        int               sz;
        logic             nop;
        logic [WIDTH-1:0] rdat;

        sz = model_q.size();
        check("issue_ready", issue_ready, m_used < DEPTH);
        check("out_valid", out_valid, sz != 0);
        check("fifo_count", fifo_count, sz);
        if (sz != 0) check("out_data", out_data, model_q[0]);
        check("err", err, exp_err());

        nop  = ovr_en ? ovr_nop  : pipe_nop[MAC_LATENCY-1];
        rdat = ovr_en ? ovr_data : pipe_data[MAC_LATENCY-1];
        issue_valid = iv;
        out_ready   = ordy;
        res_nop     = nop;
        res_data    = rdat;

        if (out_valid && ordy) dut_popped.push_back(out_data);
        if (iv && issue_ready) dut_fires++;

        ifire = iv && (m_used < DEPTH);
        pfire = ordy && (sz != 0);
        if (pfire) void'(model_q.pop_front());
        if (!nop) begin
            if (sz == m_used) m_err[ERR_SPUR] = 1'b1;
            if (sz == DEPTH && !pfire) m_err[ERR_OVF] = 1'b1;
            else model_q.push_back(rdat);
        end
        m_used = (m_used + int'(ifire) - int'(pfire)) & (2*DEPTH - 1);

        for (int i = MAC_LATENCY-1; i > 0; i--) begin
            pipe_nop[i]  = pipe_nop[i-1];
            pipe_data[i] = pipe_data[i-1];
        end
        pipe_nop[0]  = !ifire;
        pipe_data[0] = ifire ? d : $urandom;

        @(posedge clk);
        #1;
    endtask

    initial begin
        int vcycles;
        int n;
        bit can;

        ovr_en = 1'b0; ovr_nop = 1'b1; ovr_data = '0;
        dut_fires = 0;
        model_clear();
        do_reset();

        // Reset state.
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_issue_ready", issue_ready, 1'b1);
        check("rst_err", err, 2'b00);
        tick(0, 0, '0);

        // Single op: visible exactly MAC_LATENCY+1 cycles after issue, one cycle long.
        dut_popped.delete();
        vcycles = 0;
        tick(1, 1, 32'hDEADBEEF);
        for (int i = 0; i < 12; i++) begin
            if (out_valid) vcycles++;
            if (i == MAC_LATENCY) check("single_visible", out_valid, 1'b1);
            tick(0, 1, '0);
        end
        check("single_valid_cycles", vcycles, 1);
        check("single_count", dut_popped.size(), 1);
        if (dut_popped.size() > 0) check("single_data", dut_popped[0], 32'hDEADBEEF);
        check("single_credit_back", issue_ready, 1'b1);

        // Credit exhaustion.
        dut_fires = 0;
        for (int i = 0; i < 12; i++) tick(1, 0, $urandom);
        check("credit_fires", dut_fires, 8);
        check("credit_ready_low", issue_ready, 1'b0);
        for (int i = 0; i < 10; i++) tick(0, 0, '0);
        check("credit_full_count", fifo_count, 8);
        check("credit_no_ovf", err, 2'b00);
        tick(0, 1, '0);
        check("credit_ready_after_pop", issue_ready, 1'b1);
        for (int i = 0; i < 20; i++) tick(0, 1, '0);

        // Bubbles interleaved: only 5, 6, 7 may reach the output.
        do_reset();
        dut_popped.delete();
        tick(1, 1, 5); tick(0, 1, '0); tick(0, 1, '0);
        tick(1, 1, 6); tick(0, 1, '0); tick(1, 1, 7);
        for (int i = 0; i < 12; i++) tick(0, 1, '0);
        check("bubble_len", dut_popped.size(), 3);
        for (int i = 0; i < dut_popped.size() && i < 3; i++)
            check("bubble_data", dut_popped[i], i + 5);

        // Order preserved across pointer wrap: values 1..20.
        do_reset();
        dut_popped.delete();
        n = 1;
        for (int k = 0; k < 400 && n <= 20; k++) begin
            can = (m_used < DEPTH);
            tick(1, ($urandom % 3) != 0, n);
            if (can) n++;
        end
        for (int i = 0; i < 40; i++) tick(0, 1, '0);
        check("wrap_len", dut_popped.size(), 20);
        for (int i = 0; i < dut_popped.size() && i < 20; i++)
            check("wrap_data", dut_popped[i], i + 1);

        // Randomized traffic, then reset in the middle of it.
        for (int i = 0; i < 300; i++) tick($urandom % 2, ($urandom % 4) != 0, $urandom);
        do_reset();
        dut_popped.delete();
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_issue_ready", issue_ready, 1'b1);
        for (int i = 0; i < 12; i++) tick(0, 1, '0);
        check("midrst_no_output", dut_popped.size(), 0);

        // Error scenarios with forced results at the tail.
        ovr_en = 1'b1; ovr_nop = 1'b0; ovr_data = 32'h55;
        tick(0, 0, '0);
        ovr_en = 1'b0;
        tick(0, 0, '0);
        check("spur_err", err, EXP_SPUR);
        check("spur_pushed", fifo_count, 1);
        ovr_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            ovr_data = 32'h100 + i;
            tick(0, 0, '0);
        end
        ovr_data = 32'h99;
        tick(0, 1, '0);
        ovr_en = 1'b0;
        tick(0, 0, '0);
        check("full_pushpop_count", fifo_count, 8);
        check("full_pushpop_head", out_data, 32'h100);
        ovr_en = 1'b1; ovr_data = 32'hBAD;
        tick(0, 0, '0);
        ovr_en = 1'b0;
        for (int i = 0; i < 4; i++) tick(0, 0, '0);
        check("ovf_err_sticky", err, EXP_BOTH);
        check("ovf_count", fifo_count, 8);
        check("ovf_head", out_data, 32'h100);
        do_reset();
        check("err_cleared", err, 2'b00);
        tick(0, 0, '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mac_result_collector.md
Name: mac_result_collector

Overview:
- Sink end of the MAC pipeline.
- Upstream issue logic launches operations into the 7-cycle multiply+add pipeline. A non-issue cycle enters the pipeline as a NOP (NOP flag = 1).
- This block sits at the pipeline tail. It captures every non-NOP result into a FWFT FIFO and presents the results on a valid/ready output.
- It grants issue credits so the non-stallable pipeline can never overflow the FIFO.

Parameters:
- WIDTH, 32, result data width.
- DEPTH, 8, FIFO entries and credit pool size. Power of two, >= 2.
- AW, $clog2(DEPTH), derived pointer width. Not overridden.

Ports:
- clk  in  1  clock, rising edge
- aclr  in  1  reset, synchronous, active-high; sampled on posedge clk only
- issue_valid  in  1  upstream wants to launch a real (non-NOP) op this cycle
- issue_ready  out  1  credit available; op launched only when issue_valid && issue_ready
- res_nop  in  1  NOP flag from pipeline tail; 1 = bubble, 0 = valid result
- res_data  in  WIDTH  result from pipeline tail; ignored when res_nop = 1
- out_valid  out  1  FIFO head valid
- out_ready  in  1  downstream accepts head
- out_data  out  WIDTH  FIFO head data
- fifo_count  out  AW+1  current FIFO occupancy
- err  out  2  [0] overflow, [1] spurious result; sticky

Behaviour:
- Clock and reset:
  - One clock, clk.
  - aclr is synchronous active-high: state changes only at posedge clk while aclr = 1.
- Reset values:
  - FIFO empty, rd/wr pointers 0, fifo_count 0, credit counter used 0.
  - out_valid 0, err 2'b00.
  - issue_ready = 1 in the first cycle after reset.
  - out_data is don't-care while out_valid = 0.
- Credit counter used (AW+1 bits) = FIFO entries + ops in flight.
  - Update: used <= used + issue_fire - pop_fire.
    - issue_fire = issue_valid && issue_ready.
    - pop_fire = out_valid && out_ready.
  - Simultaneous issue_fire and pop_fire: used unchanged.
  - issue_ready = (used < DEPTH), combinational from the register. At used == DEPTH, issue_ready = 0 until a pop.
- Push:
  - When res_nop = 0, res_data is written at wr_ptr and wr_ptr increments modulo DEPTH.
  - Pointers wrap naturally (AW bits); fifo_count tracks occupancy separately.
- Pop:
  - FWFT: out_valid = (fifo_count != 0); out_data = mem[rd_ptr] (combinational read).
  - On pop_fire, rd_ptr increments modulo DEPTH.
- Latency:
  - A result with res_nop = 0 at edge N is visible on out_valid/out_data after edge N (cycle N+1).
  - Issue to out_valid = pipeline latency (7) + 1 cycles.
- Boundary: full FIFO
  - Push with pop_fire in the same cycle is legal; fifo_count is unchanged.
  - Push without pop while full is an overflow: data dropped, pointers and count unchanged.
- Boundary: empty FIFO
  - Push in the same cycle is not popped that cycle, because out_valid is 0.
- Spurious result:
  - Condition: res_nop = 0 while fifo_count == used (no credit in flight).
  - The push still proceeds if space exists.
- Reset mid-operation:
  - All state clears; in-flight results are lost.
  - The NOP pipeline resets to all-NOP, so no stale results arrive afterwards.

Optional Feature:
- MAC_COLLECT_ERR_EN defined:
  - err[0] sets on overflow; err[1] sets on spurious result.
  - Both bits are sticky until aclr.
- Not defined:
  - err tied to 2'b00; no detection logic.
  - Overflow still drops data silently.

Decomposition:
- Shared package mac_pkg:
  - MAC_LATENCY = 7 (multiply 5 + add 2).
  - Default MAC_WIDTH = 32.
  - err bit index constants ERR_OVF = 0, ERR_SPUR = 1.
- One sub-module, mac_result_fifo:
  - FWFT storage, pointers, count.
  - Ports: push, push_data, pop, head_valid, head_data, count, full.
- Credit counter, issue_ready and error logic stay in the top level.

Test Plan:
- Reset check: hold aclr for 3 cycles mid-traffic, release -> out_valid = 0, fifo_count = 0, issue_ready = 1, err = 0; no output before new issues.
- Single op: issue one op, feed res_nop = 0 with data 0xDEADBEEF 7 cycles later, out_ready = 1 -> out_valid high for exactly 1 cycle with 0xDEADBEEF; used returns to 0.
- Credit exhaustion: issue_valid held 1, out_ready = 0, DEPTH = 8 -> issue_ready drops after exactly 8 fires. Feed 8 results -> fifo_count = 8, no overflow. Pop one -> issue_ready = 1 next cycle.
- Concurrent push/pop at full with out_ready = 1 -> fifo_count stays 8; data order preserved across pointer wrap (values 1..20 drain in order).
- Bubbles interleaved: res_nop pattern 0,1,1,0,1,0 with data 5,x,x,6,x,7 -> output sequence exactly 5,6,7; NOP data never captured.
- Errors with MAC_COLLECT_ERR_EN:
  - res_nop = 0 with used = 0 -> err = 2'b10.
  - Forced push on full without pop -> err[0] = 1; data dropped.
  - Both bits hold until aclr.
  - Without the macro, the same stimulus gives err = 2'b00.
